// File: rtl/data_memory_hs.sv
// Handshaked Y86-64 data memory: decodes icode into a read/write/no-op, then
// performs the word access LATENCY cycles after acceptance and strobes resp_valid.
module data_memory_hs #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] vale,
  input  logic [DATA_W-1:0] vala,
  input  logic [DATA_W-1:0] valp,
  output logic              resp_valid,
  output logic [DATA_W-1:0] valm,
  output logic              memory_block_error,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]        r_state;
  logic [CW-1:0]     r_counter;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_valm;
  logic              r_err;

  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_accept;
  logic              w_access;
  logic              w_in_range;

  always_comb begin
    w_op    = OP_NONE;
    w_addr  = vale;
    w_wdata = vala;
    case (icode)
      4'd4, 4'd10: w_op = OP_WRITE;
      4'd8: begin
        w_op    = OP_WRITE;
        w_wdata = valp;
      end
      4'd5: w_op = OP_READ;
      4'd9, 4'd11: begin
        w_op   = OP_READ;
        w_addr = vala;
      end
      default: w_op = OP_NONE;
    endcase
  end

  assign req_ready  = (r_state != S_WAIT);
  assign w_accept   = req_valid && req_ready;
  assign w_access   = (r_state == S_WAIT) && (r_counter == '0);
  // Full-width compare so huge addresses never alias into the array.
  assign w_in_range = (r_addr < DATA_W'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_counter <= '0;
      r_op      <= OP_NONE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_valm    <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= w_op;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      if (w_access) begin
        if (r_op == OP_NONE) begin
          r_err <= 1'b0;
        end else begin
          r_err <= !w_in_range;
          if (r_op == OP_READ && w_in_range)
            r_valm <= r_mem[r_addr[AW-1:0]];
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_WAIT;
            r_counter <= CW'(LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (r_counter != '0) r_counter <= r_counter - 1'b1;
          else                 r_state   <= S_DONE;
        end
        S_DONE: begin
          if (w_accept) begin
            r_state   <= S_WAIT;
            r_counter <= CW'(LATENCY - 1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array kept out of the reset domain so contents survive reset.
  always_ff @(posedge clock) begin
    if (w_access && r_op == OP_WRITE && w_in_range)
      r_mem[r_addr[AW-1:0]] <= r_wdata;
  end

  assign resp_valid         = (r_state == S_DONE);
  assign busy               = (r_state == S_WAIT);
  assign valm               = r_valm;
  assign memory_block_error = r_err;

endmodule

// File: tb/tb_data_memory_hs.sv
// Self-checking bench for data_memory_hs: directed test-plan steps plus a
// randomized phase, checked against an array-based model of the Y86 memory.
module tb_data_memory_hs;

  localparam int DW  = 64;
  localparam int DEP = 1024;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    icode = 4'd0;
  logic [DW-1:0] vale = '0;
  logic [DW-1:0] vala = '0;
  logic [DW-1:0] valp = '0;
  logic          resp_valid;
  logic [DW-1:0] valm;
  logic          memory_block_error;
  logic          busy;

  data_memory_hs #(.DATA_W(DW), .DEPTH(DEP), .LATENCY(LAT)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .icode(icode),
    .vale(vale),
    .vala(vala),
    .valp(valp),
    .resp_valid(resp_valid),
    .valm(valm),
    .memory_block_error(memory_block_error),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference model: plain word array plus the last-response registers.
  logic [DW-1:0] m_mem [DEP];
  logic [DW-1:0] m_valm = '0;
  logic          m_err  = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".req_ready"}, DW'(req_ready), 64'd1);
    chk({tag, ".busy"}, DW'(busy), 64'd0);
    chk({tag, ".resp_valid"}, DW'(resp_valid), 64'd0);
    chk({tag, ".valm"}, valm, m_valm);
    chk({tag, ".err"}, DW'(memory_block_error), DW'(m_err));
  endtask

  // Applies the Y86 memory-stage rules to the model for one request.
  task automatic model_apply(input logic [3:0] ic, input logic [DW-1:0] e,
                             input logic [DW-1:0] a, input logic [DW-1:0] p);
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
    bit            is_rd, is_wr;
    is_wr = (ic == 4'd4) || (ic == 4'd10) || (ic == 4'd8);
    is_rd = (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
    addr  = (ic == 4'd9 || ic == 4'd11) ? a : e;
    data  = (ic == 4'd8) ? p : a;
    if (!is_wr && !is_rd) begin
      m_err = 1'b0;
    end else if (addr >= 64'(DEP)) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      if (is_wr) m_mem[addr] = data;
      else       m_valm = m_mem[addr];
    end
  endtask

  // Called just after a falling edge with the block idle or in its response
  // cycle; returns at the falling edge of the response cycle.
  task automatic do_req(input string tag, input logic [3:0] ic, input logic [DW-1:0] e,
                        input logic [DW-1:0] a, input logic [DW-1:0] p, input bit keep);
    req_valid = 1'b1;
    icode = ic;
    vale = e;
    vala = a;
    valp = p;
    chk({tag, ".ready_at_issue"}, DW'(req_ready), 64'd1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      if (!keep) begin
        req_valid = 1'b0;
        icode = 4'($urandom);
        vale  = {$urandom, $urandom};
        vala  = {$urandom, $urandom};
        valp  = {$urandom, $urandom};
      end
      chk({tag, ".wait_busy"}, DW'(busy), 64'd1);
      chk({tag, ".wait_ready"}, DW'(req_ready), 64'd0);
      chk({tag, ".wait_resp"}, DW'(resp_valid), 64'd0);
    end
    model_apply(ic, e, a, p);
    @(negedge clock);
    chk({tag, ".resp_valid"}, DW'(resp_valid), 64'd1);
    chk({tag, ".resp_busy"}, DW'(busy), 64'd0);
    chk({tag, ".resp_ready"}, DW'(req_ready), 64'd1);
    chk({tag, ".valm"}, valm, m_valm);
    chk({tag, ".err"}, DW'(memory_block_error), DW'(m_err));
    $display("txn %s icode=%0d vale=%h vala=%h valp=%h -> valm=%h err=%0b",
             tag, ic, e, a, p, valm, memory_block_error);
  endtask

  initial begin
    logic [3:0]    ic;
    logic [DW-1:0] addr, e, a;
    int            sel;

    // Reset state
    repeat (2) @(negedge clock);
    check_idle_outputs("reset_held");
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("after_reset");

    // Seed addresses 0..15 with known data via pushq
    for (int i = 0; i < 16; i++)
      do_req("preload", 4'd10, 64'(i), {$urandom, $urandom}, '0, 1'b0);
    @(negedge clock);
    check_idle_outputs("idle_gap");

    // Write then back-to-back read
    do_req("wr5", 4'd4, 64'd5, 64'hDEAD, '0, 1'b0);
    do_req("rd5_b2b", 4'd5, 64'd5, '0, '0, 1'b0);

    // call / ret
    do_req("call100", 4'd8, 64'd100, {$urandom, $urandom}, 64'h40, 1'b0);
    do_req("ret100", 4'd9, {$urandom, $urandom}, 64'd100, '0, 1'b0);

    // Out-of-range accesses
    do_req("push_oor", 4'd10, 64'd1024, 64'hBAD0_BAD0, '0, 1'b0);
    do_req("rd0_untouched", 4'd5, 64'd0, '0, '0, 1'b0);
    do_req("pop_oor", 4'd11, '0, 64'hFFFF_FFFF_FFFF_FFFF, '0, 1'b0);

    // No-op held through WAIT, re-accepted only at the response cycle
    @(negedge clock);
    do_req("nop_hold", 4'd2, 64'd3, 64'd4, 64'd5, 1'b1);
    do_req("nop_again", 4'd2, 64'd3, 64'd4, 64'd5, 1'b0);

    // Reset during WAIT aborts a write to address 7
    @(negedge clock);
    req_valid = 1'b1;
    icode = 4'd4;
    vale = 64'd7;
    vala = 64'h11;
    @(negedge clock);
    req_valid = 1'b0;
    chk("abort.busy_before", DW'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    m_valm = '0;
    m_err  = 1'b0;
    check_idle_outputs("abort.async");
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clock);
      chk("abort.no_resp", DW'(resp_valid), 64'd0);
    end
    do_req("rd7_after_abort", 4'd5, 64'd7, '0, '0, 1'b0);

    // Randomized mix: in-range addresses stay in the seeded window
    for (int n = 0; n < 60; n++) begin
      ic  = 4'($urandom_range(0, 11));
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = 64'd1024 + 64'($urandom_range(0, 5000));
      else if (sel == 1) addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      else               addr = 64'($urandom_range(0, 15));
      e = {$urandom, $urandom};
      a = {$urandom, $urandom};
      if (ic == 4'd9 || ic == 4'd11) a = addr;
      else                           e = addr;
      if ($urandom_range(0, 1) == 1) @(negedge clock);
      do_req("rand", ic, e, a, {$urandom, $urandom}, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
- Parametrised, handshaked successor to the single-cycle combinational data memory in the Y86-64 memory stage.
- Decodes icode to choose a memory read or write, address and write data, then performs the access after a configurable number of wait cycles.
- Returns valm and an error flag through a valid-strobe handshake.
- Sits between the execute/memory stage and writeback; lets SEQ/PIPE control stall on a slow memory.

Parameters:
- DATA_W, 64, width of vale/vala/valp/valm and of each memory word.
- DEPTH, 1024, number of words; word-addressed, legal addresses 0..DEPTH-1.
- LATENCY, 2, cycles from request acceptance to the access edge; legal range >= 1.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present on icode/vale/vala/valp.
- req_ready  output  1  block can accept a request this cycle.
- icode  input  4  Y86 instruction code of the request.
- vale  input  DATA_W  ALU result (address for rmmovq/mrmovq/pushq/call).
- vala  input  DATA_W  register A value (write data, or address for ret/popq).
- valp  input  DATA_W  next PC (write data for call).
- resp_valid  output  1  one-cycle strobe: valm/memory_block_error are valid.
- valm  output  DATA_W  read data.
- memory_block_error  output  1  out-of-range access for the response just strobed.
- busy  output  1  high while a request is outstanding (WAIT state).

Behaviour:
- Reset, asynchronous: state=IDLE, req_ready=1, resp_valid=0, valm=0, memory_block_error=0, busy=0, counter=0. Memory array is not cleared.
- Decode, latched at acceptance:
  - icode 4 (rmmovq) and 10 (pushq): write vala to addr vale.
  - icode 8 (call): write valp to addr vale.
  - icode 5 (mrmovq): read addr vale.
  - icode 9 (ret) and 11 (popq): read addr vala.
  - Any other icode: no memory operation.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. The block latches the op, addr, wdata and icode class. Inputs may change freely afterwards.
- States:
  - IDLE: req_ready=1. On accept, go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0, busy=1. If counter != 0, decrement. If counter == 0, perform the access on this edge and go to DONE.
  - DONE: resp_valid=1, req_ready=1, busy=0. On accept, go to WAIT (back-to-back). Otherwise go to IDLE.
- Timing: request accepted at edge 0, access at edge LATENCY, resp_valid high during the cycle following edge LATENCY. Maximum throughput is one request per LATENCY+1 cycles.
- Access edge:
  - Range check compares the full DATA_W address against DEPTH.
  - If the address is >= DEPTH: memory_block_error=1, no write, valm holds its previous value.
  - Otherwise memory_block_error=0.
  - Write op: mem[addr] <= wdata; valm holds.
  - Read op: valm <= mem[addr].
  - No-op icode: no access, memory_block_error=0, valm holds, resp_valid still strobes.
- valm and memory_block_error hold their values until the next access edge. memory_block_error is not sticky.
- Ordering: requests are strictly serialised, so a read after a write to the same address returns the new data.
- Reset mid-operation: an outstanding request is aborted. A write that has not reached its access edge never commits, and no resp_valid is produced.
- req_valid asserted while req_ready=0 is ignored. The requester must hold it until accepted.

Test Plan:
- Reset with LATENCY=2: all outputs at reset values; req_ready=1. Write icode=4, vale=5, vala=0xDEAD accepted at edge 0 -> busy high for cycles 1–2; resp_valid only in cycle 3; memory_block_error=0.
- Read-back: icode=5, vale=5 issued back-to-back during DONE of the previous write -> accepted; valm=0xDEAD with resp_valid 3 cycles later.
- Call then ret: icode=8, vale=100, valp=0x40 -> write. Then icode=9, vala=100 -> valm=0x40.
- Out-of-range:
  - icode=10, vale=1024 -> memory_block_error=1 with resp_valid; mem[1024 mod 1024]=mem[0] is unchanged.
  - icode=11, vala=0xFFFF_FFFF_FFFF_FFFF -> memory_block_error=1; valm unchanged.
- Reset mid-write: icode=4, vale=7, vala=0x11 accepted; reset asserted during WAIT -> no resp_valid. A later read of addr 7 returns the prior contents, not 0x11.
- No-op icode=2 plus stall: resp_valid after LATENCY+1 cycles; valm unchanged; memory_block_error=0. A req_valid held during WAIT is not accepted until DONE.
